// File: rtl/scs8hd_stream_pkg.sv
// Shared definitions for the scs8hd stream-steering cells.
// It holds the channel indices and the FIFO occupancy width helper.
package scs8hd_stream_pkg;

  localparam bit CH0 = 1'b0;
  localparam bit CH1 = 1'b1;

  // Occupancy counters must hold 0..DEPTH inclusive, hence one extra bit.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/scs8hd_demux2_reg_chk.sv
// Simulation-only observer for the demux: flags a valid word whose route select is unknown.
module scs8hd_demux2_reg_chk (
  input logic clk,
  input logic reset,
  input logic A_valid,
  input logic S
);

  // An unknown select on a valid word cannot be routed; the demux drops the push.
  always @(posedge clk) begin
    if (!reset && A_valid) begin
      assert (!$isunknown(S))
        else $error("scs8hd_demux2_reg: A_valid with unknown S, word not pushed");
    end
  end

endmodule

// File: rtl/scs8hd_demux_fifo.sv
// Per-channel synchronous FIFO for the registered 1:2 demux.
// A push into a full FIFO and a pop from an empty FIFO are both ignored.
module scs8hd_demux_fifo
  import scs8hd_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    push_ok_s = push && !full_s;
    pop_ok_s  = pop && !empty_s;
  end

  // Storage, pointer and occupancy update; reset flushes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/scs8hd_demux2_reg.sv
// Registered 1:2 stream demultiplexer: routes A to X0 or X1 by S, with one FIFO per channel.
module scs8hd_demux2_reg
  import scs8hd_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW = count_width(DEPTH)
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic             A_valid,
  output logic             A_ready,
  input  logic             S,
  output logic [WIDTH-1:0] X0,
  output logic             X0_valid,
  input  logic             X0_ready,
  output logic [WIDTH-1:0] X1,
  output logic             X1_valid,
  input  logic             X1_ready,
  output logic [CW-1:0]    X0_count,
  output logic [CW-1:0]    X1_count
);

  logic [1:0]       push_s;
  logic [1:0]       pop_s;
  logic [1:0]       full_s;
  logic [1:0]       empty_s;
  logic [WIDTH-1:0] head0_s;
  logic [WIDTH-1:0] head1_s;
  logic             a_ready_s;

  // Ready depends only on S and the registered fill state, never on the consumers.
  always_comb begin
    a_ready_s = 1'b0;
    push_s    = 2'b00;
    case (S)
      1'b0:    a_ready_s = !reset && !full_s[CH0];
      1'b1:    a_ready_s = !reset && !full_s[CH1];
      default: a_ready_s = 1'b0;
    endcase
    if (A_valid && a_ready_s) begin
      case (S)
        1'b0:    push_s[CH0] = 1'b1;
        1'b1:    push_s[CH1] = 1'b1;
        default: push_s      = 2'b00;
      endcase
    end else begin
      push_s = 2'b00;
    end
  end

  // Pops are only honoured for a channel that is presenting a word.
  always_comb begin
    pop_s[CH0] = X0_ready && !empty_s[CH0];
    pop_s[CH1] = X1_ready && !empty_s[CH1];
  end

  scs8hd_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push_s[CH0]),
    .wdata (A),
    .pop   (pop_s[CH0]),
    .head  (head0_s),
    .count (X0_count),
    .full  (full_s[CH0]),
    .empty (empty_s[CH0])
  );

  scs8hd_demux_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push_s[CH1]),
    .wdata (A),
    .pop   (pop_s[CH1]),
    .head  (head1_s),
    .count (X1_count),
    .full  (full_s[CH1]),
    .empty (empty_s[CH1])
  );

  // Outputs read straight from FIFO registers; stale heads are masked to zero.
  always_comb begin
    A_ready  = a_ready_s;
    X0_valid = !empty_s[CH0];
    X1_valid = !empty_s[CH1];
    if (empty_s[CH0]) begin
      X0 = {WIDTH{1'b0}};
    end else begin
      X0 = head0_s;
    end
    if (empty_s[CH1]) begin
      X1 = {WIDTH{1'b0}};
    end else begin
      X1 = head1_s;
    end
  end

`ifndef functional
  scs8hd_demux2_reg_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .A_valid (A_valid),
    .S       (S)
  );
`endif

endmodule

// File: tb/tb_scs8hd_demux2_reg.sv
// Scoreboard bench for scs8hd_demux2_reg: per-channel expected-word queues, directed plus random traffic.
module tb_scs8hd_demux2_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] A = '0;
  logic             A_valid = 1'b0;
  logic             A_ready;
  logic             S = 1'b0;
  logic [WIDTH-1:0] X0, X1;
  logic             X0_valid, X1_valid;
  logic             X0_ready = 1'b0;
  logic             X1_ready = 1'b0;
  logic [CW-1:0]    X0_count, X1_count;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  scs8hd_demux2_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
`ifdef SC_USE_PG_PIN
    .vpwr     (1'b1),
    .vgnd     (1'b0),
    .vpb      (1'b1),
    .vnb      (1'b0),
`endif
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .A_valid  (A_valid),
    .A_ready  (A_ready),
    .S        (S),
    .X0       (X0),
    .X0_valid (X0_valid),
    .X0_ready (X0_ready),
    .X1       (X1),
    .X1_valid (X1_valid),
    .X1_ready (X1_ready),
    .X0_count (X0_count),
    .X1_count (X1_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Producer protocol: a stalled word must stay unchanged while A_valid is held.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_a;
  logic       prev_s;
  always @(posedge clk) begin
    if (prev_stall && A_valid) begin
      assert (A == prev_a && S == prev_s) else $error("producer changed A/S while stalled");
    end
    prev_stall <= A_valid && !A_ready && !reset;
    prev_a     <= A;
    prev_s     <= S;
  end

  // Monitor: outputs versus model queues, then retire words the consumers take this edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        chk("X0_count", 32'(X0_count), 32'(q0.size()));
        chk("X0_valid", 32'(X0_valid), 32'(q0.size() != 0));
        chk("X0_data",  32'(X0), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        chk("X1_count", 32'(X1_count), 32'(q1.size()));
        chk("X1_valid", 32'(X1_valid), 32'(q1.size() != 0));
        chk("X1_data",  32'(X1), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
        if (q0.size() != 0 && X0_ready) void'(q0.pop_front());
        if (q1.size() != 0 && X1_ready) void'(q1.pop_front());
      end
    end
  end

  // One cycle of stimulus: drive, check ready against the model, record the accepted word.
  task automatic drive(input logic rst, input logic av, input logic s, input logic [7:0] a,
                       input logic r0, input logic r1, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    reset    = rst;
    A_valid  = av;
    S        = s;
    A        = a;
    X0_ready = r0;
    X1_ready = r1;
    #2;
    exp_rdy = !rst && ((s ? q1.size() : q0.size()) < DEPTH);
    chk("A_ready", 32'(A_ready), 32'(exp_rdy));
    acc = av && exp_rdy;
    #2;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else if (acc) begin
      if (s) q1.push_back(a);
      else   q0.push_back(a);
    end
  endtask

  task automatic idle(input int n, input logic r0, input logic r1);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, r0, r1, acc);
  endtask

  initial begin
    logic       acc;
    logic       pend;
    logic [7:0] pa;
    logic       ps;
    logic       rst, av, r0, r1;

    // Reset held two cycles with traffic offered and consumers ready.
    drive(1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b1, acc);
    mon_en = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 8'h44, 1'b1, 1'b1, acc);

    // Routing to each channel.
    drive(1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Channel 0 stalled until full; channel 1 still flows.
    drive(1'b0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, acc);

    // Full channel with a simultaneous pop: no write-through, accepted next cycle.
    drive(1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, acc);
    drive(1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Back-to-back streaming through channel 1.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 8'(i), 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Fill both channels, then reset mid-operation.
    drive(1'b0, 1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, acc);
    drive(1'b0, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, acc);
    drive(1'b0, 1'b1, 1'b1, 8'hD0, 1'b0, 1'b0, acc);
    drive(1'b0, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    drive(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, acc);
    idle(3, 1'b1, 1'b1);

    // Random traffic with random backpressure and occasional resets.
    pend = 1'b0;
    pa   = 8'h00;
    ps   = 1'b0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      if (pend) begin
        av = 1'b1;
      end else begin
        av = ($urandom_range(0, 3) != 0);
        pa = 8'($urandom);
        ps = 1'($urandom);
      end
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 1) != 0);
      drive(rst, av, ps, pa, r0, r1, acc);
      pend = av && !acc && !rst;
    end
    idle(4, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scs8hd_demux2_reg.md
Name: scs8hd_demux2_reg

Overview:
- Registered 1-to-2 stream demultiplexer; the routing counterpart of the 2:1 mux cell.
- Steers each input word on A to output channel X0 or X1, chosen by select S sampled at the accept edge.
- Each output channel has a small FIFO so one stalled consumer does not block traffic to the other until that channel's FIFO fills.
- Sits between one producer and two consumers in datapath/scan-steering logic built from this cell library.

Parameters:
- WIDTH, 8, data width of A, X0, X1.
- DEPTH, 2, entries per output FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- A  input  WIDTH  input data word
- A_valid  input  1  producer has a word on A
- A_ready  output  1  word on A is accepted this cycle if A_valid=1
- S  input  1  route select, qualified by A_valid; 0 selects X0, 1 selects X1
- X0  output  WIDTH  channel 0 head word
- X0_valid  output  1  X0 holds a valid word
- X0_ready  input  1  channel 0 consumer takes X0
- X1  output  WIDTH  channel 1 head word
- X1_valid  output  1  X1 holds a valid word
- X1_ready  input  1  channel 1 consumer takes X1
- X0_count  output  $clog2(DEPTH)+1  channel 0 occupancy
- X1_count  output  $clog2(DEPTH)+1  channel 1 occupancy
- Power pins vpwr, vgnd, vpb, vnb exist only when SC_USE_PG_PIN is defined; otherwise they are internal supplies.

Behaviour:
- Reset: on a clk edge with reset=1, all read/write pointers and counts go to 0. Resulting outputs: X0_valid=X1_valid=0, X0=X1=0, X0_count=X1_count=0.
- A_ready is forced to 0 whenever reset=1.
- Reset mid-operation: all buffered words are discarded; no partial word survives.
- Accept: A_valid & A_ready at an edge. The word is pushed into FIFO[S]; S is sampled on that same edge.
- A_ready = !full[S]. It is combinational from S and the registered counts only, never from X*_ready, so there is no ready-to-ready path.
- Full FIFO with simultaneous pop: A_ready stays 0. There is no write-through-on-pop into a full FIFO.
- Latency: a word accepted at edge n appears on X[S] with X[S]_valid=1 after edge n, i.e. 1 cycle. There is no combinational A-to-X path.
- Output: Xk_valid = (countk != 0). Xk is the FIFO head when valid, and forced to 0 when not valid.
- Pop: Xk_valid & Xk_ready at an edge advances the read pointer of channel k.
- Push and pop on the same channel in one edge: count unchanged; the head advances and the tail is written.
- Empty FIFO with a push: valid rises next cycle. There is no same-cycle bypass.
- Push to one channel and pop from the other in the same edge are independent.
- Ordering: words are strictly FIFO per channel. Ordering between channels is not defined.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts range 0..DEPTH.
- Simulation check: A_valid=1 with S at X/Z triggers an $error under `ifndef functional`. No push occurs in that case.
- Xk_ready while Xk_valid=0 is ignored.
- A_valid while A_ready=0 is not an error. The producer holds A and S stable until accepted; this is a protocol requirement the bench checks with an assertion.

Decomposition:
- Shared package scs8hd_stream_pkg holds:
  - localparam function for count width, $clog2(DEPTH)+1
  - channel index constants CH0=0, CH1=1
- Sub-module scs8hd_demux_fifo: WIDTH/DEPTH synchronous FIFO with push, pop, head, count, full and empty, clk/reset.
- The top instantiates scs8hd_demux_fifo twice and adds the A_ready select, push steering, and X-zero gating.

Test Plan:
- Reset: hold reset=1 for 2 cycles with A_valid=1 and X0_ready=X1_ready=1 -> A_ready=0, X0_valid=X1_valid=0, X0=X1=0, counts=0 throughout.
- Routing: after reset, send A=8'h11 with S=0, then A=8'h22 with S=1, both consumers ready -> X0=8'h11 valid one cycle after first accept; X1=8'h22 one cycle after second accept; each valid for exactly one cycle.
- Backpressure and full: X0_ready=0; send 8'hA0, A1, A2 all with S=0 -> first two accepted, X0_count=2, A_ready=0 while S=0. Set S=1 with A=8'hB0 -> accepted immediately, X1=8'hB0 next cycle.
- Full plus simultaneous pop: X0 FIFO full (A0, A1), raise X0_ready=1 with A_valid=1, S=0, A=A2 -> no accept that edge, X0 shows A0 then A1. A2 is accepted the following cycle, and the output order is A0, A1, A2.
- Same-channel push/pop streaming: X1_ready=1 continuously; send 8 back-to-back words 0..7 on S=1 -> A_ready stays 1, X1_count stays ≤1, X1 outputs 0..7 in order with 1-cycle latency.
- Reset mid-operation: both FIFOs hold 2 words; assert reset for 1 cycle -> next cycle both valids=0 and counts=0. A new word 8'h5A on S=0 appears alone on X0.
